trg_link_sched: RTL

- Schedules the single 16-bit + K-flag trigger link (main FPGA -> channel FPGAs) among three sources: trigger tokens, periodic timestamp-sync frames and software command frames.
- Idle filler is comma K28.5. Trigger tokens always win arbitration. Multi-word frames are atomic, so trigger latency is bounded.
- Sits between the trigger generator and the link serializer, in the 125 MHz link clock domain.

---
 rtl/trg_link_sched_if.sv | 21 ++
 rtl/trg_link_sched.sv | 100 ++++++++++
 2 files changed

// File: rtl/trg_link_sched_if.sv
// trg_link_sched_if: trigger-link scheduler bus (trigger/command inputs, link word and status outputs).
interface trg_link_sched_if #(parameter int LOST_W = 16);
  logic              trg_req;
  logic [14:0]       trg_tok;
  logic              cmd_valid;
  logic [15:0]       cmd_data;
  logic              cmd_ready;
  logic              sync_en;
  logic [15:0]       link_data;
  logic              link_kchar;
  logic [LOST_W-1:0] trg_lost;
  logic [31:0]       ts;
  modport master (
    output trg_req, trg_tok, cmd_valid, cmd_data, sync_en,
    input  cmd_ready, link_data, link_kchar, trg_lost, ts
  );
  modport slave (
    input  trg_req, trg_tok, cmd_valid, cmd_data, sync_en,
    output cmd_ready, link_data, link_kchar, trg_lost, ts
  );
endinterface

// File: rtl/trg_link_sched.sv
// trg_link_sched: arbitrates trigger tokens, sync frames and command frames onto the trigger link.
// Macro TRGSCHED_CMD_PRIO_EN: commands outrank sync, with a 16-cycle sync starvation guard.
module trg_link_sched #(
  parameter int SYNC_PERIOD = 125000000,
  parameter int LOST_W      = 16
) (
  input logic            clk,
  input logic            rst,
  trg_link_sched_if.slave bus
);
  localparam int CW = $clog2(SYNC_PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(SYNC_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, CMD_D, SYNC_H, SYNC_L} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt;
  logic              sync_due, pend;
  logic [14:0]       pend_tok;
  logic [15:0]       cmd_lat, link, data_n;
  logic [31:0]       ts, ts_lat;
  logic [LOST_W-1:0] lost;
  logic              kchar, k_n, trg_go, sync_go, idle, issue, rdy;
`ifdef TRGSCHED_CMD_PRIO_EN
  logic [4:0]        starve;
  always_ff @(posedge clk)
    if (rst) starve <= '0;
    else starve <= (sync_due & bus.sync_en & !issue) ? (starve[4] ? starve : starve + 5'd1) : '0;
`endif
  always_comb begin
    trg_go = pend | bus.trg_req;
`ifdef TRGSCHED_CMD_PRIO_EN
    sync_go = sync_due & bus.sync_en & (starve[4] | !bus.cmd_valid);
`else
    sync_go = sync_due & bus.sync_en;
`endif
    idle = state == IDLE;
    issue = idle & !trg_go & sync_go;
    rdy = idle & !trg_go & !sync_go & bus.cmd_valid & !rst;
    state_n = IDLE;
    data_n = 16'h00BC;
    k_n = 1'b1;
    case (state)
      IDLE:
        if (trg_go) begin
          data_n = {1'b1, pend ? pend_tok : bus.trg_tok};
          k_n = 1'b0;
        end else if (sync_go) begin
          data_n = 16'h00FC;
          state_n = SYNC_H;
        end else if (bus.cmd_valid) begin
          data_n = 16'h003C;
          state_n = CMD_D;
        end
      CMD_D: begin
        data_n = cmd_lat;
        k_n = 1'b0;
      end
      SYNC_H: begin
        data_n = ts_lat[31:16];
        k_n = 1'b0;
        state_n = SYNC_L;
      end
      default: begin
        data_n = ts_lat[15:0];
        k_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      link <= 16'h00BC;
      kchar <= 1'b1;
      pend <= 1'b0;
      pend_tok <= '0;
      sync_due <= 1'b0;
      cnt <= RELOAD;
      lost <= '0;
      ts <= '0;
      ts_lat <= '0;
      cmd_lat <= '0;
    end else begin
      state <= state_n;
      link <= data_n;
      kchar <= k_n;
      ts <= ts + 32'd1;
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
      sync_due <= bus.sync_en & ((cnt == '0) | (sync_due & !issue));
      if (issue) ts_lat <= ts;
      if (rdy) cmd_lat <= bus.cmd_data;
      // In IDLE a held token is sent and a simultaneous new one takes its slot.
      pend <= idle ? (pend & bus.trg_req) : (pend | bus.trg_req);
      if (bus.trg_req & (idle ? pend : !pend)) pend_tok <= bus.trg_tok;
      if (!idle & bus.trg_req & pend & (lost != '1)) lost <= lost + 1'b1;
    end
  assign bus.cmd_ready  = rdy;
  assign bus.link_data  = link;
  assign bus.link_kchar = kchar;
  assign bus.trg_lost   = lost;
  assign bus.ts         = ts;
endmodule
